uart_cmd_parser: RTL and testbench

Parses the host keystroke stream delivered by the UART receiver into clock commands: set time, set alarm, enable and disable alarm. It sits directly downstream of the UART receive path, alongside `resetGen`, which watches the same byte stream for ESC. It drives one-cycle BCD load strobes into the lab clock/alarm datapath and, optionally, echoes accepted characters back toward the transmit path.

---
 rtl/cmd_pkg.sv | 31 +++
 rtl/ascii_bcd_check.sv | 18 +
 rtl/uart_cmd_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared types and ASCII constants for the UART command parser
package cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D0,
        ST_D1,
        ST_D2,
        ST_D3
    } state_e;

    typedef enum logic {
        CMD_TIME,
        CMD_ALARM
    } cmd_e;

    localparam logic [7:0] ASC_0      = 8'h30;
    localparam logic [7:0] ASC_ESC    = 8'h1B;
    localparam logic [7:0] ASC_T      = 8'h54;
    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_E      = 8'h45;
    localparam logic [7:0] ASC_D      = 8'h44;
    localparam logic [7:0] ASC_QMARK  = 8'h3F;
    localparam logic [7:0] ASC_LC_OFS = 8'h20;

    // Case-insensitive match against an uppercase letter.
    function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
        return (b == upper) || (b == (upper + ASC_LC_OFS));
    endfunction

endpackage

// File: rtl/ascii_bcd_check.sv
// rtl/ascii_bcd_check.sv - combinational ASCII digit decode with range check
module ascii_bcd_check
    import cmd_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic [3:0] max_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    logic [7:0] diff;

    // Bytes below '0' wrap to large values, so a single compare covers both bounds.
    assign diff    = byte_i - ASC_0;
    assign digit_o = diff[3:0];
    assign legal_o = (diff <= {4'b0000, max_i});

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - keystroke parser for set-time/set-alarm/arm commands
// Optional echo of accepted bytes toward the transmitter when CMD_ECHO_EN is defined.
module uart_cmd_parser
    import cmd_pkg::*;
#(
    parameter int TENS_MAX = 5,
    parameter int ONES_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bu_rx_data_rdy,
    input  logic [7:0] bu_rx_data,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic [3:0] ld_Mtens,
    output logic [3:0] ld_Mones,
    output logic [3:0] ld_Stens,
    output logic [3:0] ld_Sones,
    output logic       alarm_en,
    output logic       cmd_err,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy
);

    state_e     state_q;
    cmd_e       cmd_q;
    logic [3:0] sh_mtens_q, sh_mones_q, sh_stens_q;
    logic [3:0] ld_mtens_q, ld_mones_q, ld_stens_q, ld_sones_q;
    logic       ld_time_q, ld_alarm_q, cmd_err_q, alarm_en_q;

    logic [3:0] max_sel;
    logic [3:0] digit;
    logic       legal;
    logic       is_esc, is_t, is_a, is_e, is_d;

    assign max_sel = (state_q == ST_D0 || state_q == ST_D2) ? 4'(TENS_MAX) : 4'(ONES_MAX);

    ascii_bcd_check u_chk (
        .byte_i  (bu_rx_data),
        .max_i   (max_sel),
        .digit_o (digit),
        .legal_o (legal)
    );

    assign is_esc = (bu_rx_data == ASC_ESC);
    assign is_t   = is_letter(bu_rx_data, ASC_T);
    assign is_a   = is_letter(bu_rx_data, ASC_A);
    assign is_e   = is_letter(bu_rx_data, ASC_E);
    assign is_d   = is_letter(bu_rx_data, ASC_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_TIME;
            sh_mtens_q <= 4'd0;
            sh_mones_q <= 4'd0;
            sh_stens_q <= 4'd0;
            ld_mtens_q <= 4'd0;
            ld_mones_q <= 4'd0;
            ld_stens_q <= 4'd0;
            ld_sones_q <= 4'd0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            alarm_en_q <= 1'b0;
        end else begin
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (bu_rx_data_rdy) begin
                if (is_esc) begin
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (is_t) begin
                                cmd_q   <= CMD_TIME;
                                state_q <= ST_D0;
                            end else if (is_a) begin
                                cmd_q   <= CMD_ALARM;
                                state_q <= ST_D0;
                            end else if (is_e) begin
                                alarm_en_q <= 1'b1;
                            end else if (is_d) begin
                                alarm_en_q <= 1'b0;
                            end
                        end
                        ST_D0, ST_D1, ST_D2, ST_D3: begin
                            if (!legal) begin
                                cmd_err_q <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                case (state_q)
                                    ST_D0: begin
                                        sh_mtens_q <= digit;
                                        state_q    <= ST_D1;
                                    end
                                    ST_D1: begin
                                        sh_mones_q <= digit;
                                        state_q    <= ST_D2;
                                    end
                                    ST_D2: begin
                                        sh_stens_q <= digit;
                                        state_q    <= ST_D3;
                                    end
                                    default: begin
                                        ld_mtens_q <= sh_mtens_q;
                                        ld_mones_q <= sh_mones_q;
                                        ld_stens_q <= sh_stens_q;
                                        ld_sones_q <= digit;
                                        ld_time_q  <= (cmd_q == CMD_TIME);
                                        ld_alarm_q <= (cmd_q == CMD_ALARM);
                                        state_q    <= ST_IDLE;
                                    end
                                endcase
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign ld_time  = ld_time_q;
    assign ld_alarm = ld_alarm_q;
    assign ld_Mtens = ld_mtens_q;
    assign ld_Mones = ld_mones_q;
    assign ld_Stens = ld_stens_q;
    assign ld_Sones = ld_sones_q;
    assign alarm_en = alarm_en_q;
    assign cmd_err  = cmd_err_q;

`ifdef CMD_ECHO_EN
    logic       in_cmd, accept_c, err_c;
    logic [7:0] tx_data_q;
    logic       tx_rdy_q;

    assign in_cmd   = (state_q != ST_IDLE);
    assign accept_c = bu_rx_data_rdy && !is_esc &&
                      (in_cmd ? legal : (is_t || is_a || is_e || is_d));
    assign err_c    = bu_rx_data_rdy && !is_esc && in_cmd && !legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q <= 8'h00;
            tx_rdy_q  <= 1'b0;
        end else begin
            tx_rdy_q <= accept_c || err_c;
            if (err_c) begin
                tx_data_q <= ASC_QMARK;
            end else if (accept_c) begin
                tx_data_q <= bu_rx_data;
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_data_rdy = tx_rdy_q;
`else
    assign tx_data     = 8'h00;
    assign tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized self-checking bench with behavioural command model
module tb_uart_cmd_parser;

    localparam int TMAX = 5;
    localparam int OMAX = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [7:0] data;
    logic       ld_time, ld_alarm, alarm_en, cmd_err, tx_data_rdy;
    logic [3:0] ld_Mtens, ld_Mones, ld_Stens, ld_Sones;
    logic [7:0] tx_data;

    int total = 0;
    int passed = 0;

    uart_cmd_parser #(.TENS_MAX(TMAX), .ONES_MAX(OMAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .bu_rx_data_rdy (rdy),
        .bu_rx_data     (data),
        .ld_time        (ld_time),
        .ld_alarm       (ld_alarm),
        .ld_Mtens       (ld_Mtens),
        .ld_Mones       (ld_Mones),
        .ld_Stens       (ld_Stens),
        .ld_Sones       (ld_Sones),
        .alarm_en       (alarm_en),
        .cmd_err        (cmd_err),
        .tx_data        (tx_data),
        .tx_data_rdy    (tx_data_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: collected digits and pending command kind.
    logic       m_active, m_is_alarm, m_en, m_ld_time, m_ld_alarm, m_err, m_txr;
    int         m_cnt;
    logic [3:0] m_dig [4];
    logic [3:0] m_ld  [4];
    logic [7:0] m_tx;

    always @(posedge clk or posedge rst) begin
        logic [7:0] b, u;
        int lim;
        if (rst) begin
            m_active <= 0; m_is_alarm <= 0; m_en <= 0; m_cnt <= 0;
            m_ld_time <= 0; m_ld_alarm <= 0; m_err <= 0; m_txr <= 0; m_tx <= 8'h00;
            for (int i = 0; i < 4; i++) begin m_dig[i] <= 0; m_ld[i] <= 0; end
        end else begin
            m_ld_time <= 0; m_ld_alarm <= 0; m_err <= 0; m_txr <= 0;
            if (rdy) begin
                b = data;
                u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
                if (b == 8'h1B) begin
                    m_active <= 0;
                end else if (!m_active) begin
                    if (u == 8'h54 || u == 8'h41) begin
                        m_active <= 1; m_is_alarm <= (u == 8'h41); m_cnt <= 0;
                        m_txr <= 1; m_tx <= b;
                    end else if (u == 8'h45 || u == 8'h44) begin
                        m_en <= (u == 8'h45);
                        m_txr <= 1; m_tx <= b;
                    end
                end else begin
                    lim = (m_cnt == 0 || m_cnt == 2) ? TMAX : OMAX;
                    if (b >= 8'h30 && int'(b) <= 8'h30 + lim) begin
                        m_txr <= 1; m_tx <= b;
                        if (m_cnt == 3) begin
                            for (int i = 0; i < 3; i++) m_ld[i] <= m_dig[i];
                            m_ld[3] <= 4'(b - 8'h30);
                            m_ld_time <= !m_is_alarm; m_ld_alarm <= m_is_alarm;
                            m_active <= 0;
                        end else begin
                            m_dig[m_cnt] <= 4'(b - 8'h30);
                            m_cnt <= m_cnt + 1;
                        end
                    end else begin
                        m_err <= 1; m_active <= 0;
                        m_txr <= 1; m_tx <= 8'h3F;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ld_time", ld_time, m_ld_time);
        check("ld_alarm", ld_alarm, m_ld_alarm);
        check("cmd_err", cmd_err, m_err);
        check("alarm_en", alarm_en, m_en);
        check("digits", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones},
              {m_ld[0], m_ld[1], m_ld[2], m_ld[3]});
`ifdef CMD_ECHO_EN
        check("tx_data_rdy", tx_data_rdy, m_txr);
        check("tx_data", tx_data, m_tx);
`else
        check("tx_data_rdy", tx_data_rdy, 1'b0);
        check("tx_data", tx_data, 8'h00);
`endif
    end

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic send(input logic [7:0] b);
        rdy = 1'b1; data = b;
        @(posedge clk); #1;
        rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [7:0] letters [8] = '{8'h54, 8'h74, 8'h41, 8'h61, 8'h45, 8'h65, 8'h44, 8'h64};

    initial begin
        rst = 1'b1; rdy = 1'b0; data = 8'h00;
        idle(2);
        check("rst_ld_time", ld_time, 1'b0);
        check("rst_alarm_en", alarm_en, 1'b0);
        check("rst_digits", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h0000);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        idle(1);

        send(8'h54); send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        check("lit_t1234_pulse", ld_time, 1'b1);
        check("lit_t1234_digits", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h1234);
        check("lit_t1234_alarm", ld_alarm, 1'b0);
        idle(1);
        check("lit_t1234_single", ld_time, 1'b0);

        send(8'h61); send(8'h35); send(8'h39); send(8'h35); send(8'h39);
        check("lit_a5959_pulse", ld_alarm, 1'b1);
        check("lit_a5959_digits", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h5959);
        idle(1);

        send(8'h54);
`ifdef CMD_ECHO_EN
        check("lit_echo_t", {tx_data_rdy, tx_data}, 9'h154);
`endif
        send(8'h36);
        check("lit_err_pulse", cmd_err, 1'b1);
        check("lit_err_hold", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h5959);
`ifdef CMD_ECHO_EN
        check("lit_echo_q", {tx_data_rdy, tx_data}, 9'h13F);
`endif
        send(8'h78);
        check("lit_x_ignored", {cmd_err, ld_time, ld_alarm}, 3'b000);

        send(8'h41); send(8'h31); send(8'h32); send(8'h1B);
        check("lit_esc_noerr", cmd_err, 1'b0);
        send(8'h41); send(8'h30); send(8'h30); send(8'h30); send(8'h30);
        check("lit_a0000_pulse", ld_alarm, 1'b1);
        check("lit_a0000_digits", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h0000);

        send(8'h45);
        check("lit_en_set", alarm_en, 1'b1);
        send(8'h64);
        check("lit_en_clr", alarm_en, 1'b0);
        send(8'h45);
        send(8'h54); send(8'h31);
        rst = 1'b1; #1;
        check("lit_rst_async_en", alarm_en, 1'b0);
        check("lit_rst_async_dig", {ld_Mtens, ld_Mones, ld_Stens, ld_Sones}, 16'h0000);
        idle(2);
        rst = 1'b0;
        send(8'h32); send(8'h33); send(8'h34);
        check("lit_rst_noload", {ld_time, ld_alarm, cmd_err}, 3'b000);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; idle(2); rst = 1'b0;
            end
            if ($urandom_range(0, 9) < 6) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: send(8'h30 + 8'($urandom_range(0, 9)));
                    4, 5:       send(letters[$urandom_range(0, 7)]);
                    6:          send(($urandom_range(0, 1) == 1) ? 8'h1B : 8'($urandom_range(0, 255)));
                    7:          send(($urandom_range(0, 1) == 1) ? 8'h2F : 8'h3A);
                    default:    send(8'h30 + 8'($urandom_range(0, 5)));
                endcase
            end else begin
                idle(1);
            end
        end
        idle(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
